root_input_unit: RTL and testbench
==================================

# root_input_unit

Receiver for the LOCAL port link driven by the root output unit. It captures flits presented as `in_data_valid`/`in_data` into an internal first-word-fall-through buffer and presents them to a consumer over a valid/ready handshake. It returns one `upstream_credit` pulse per flit consumed, so the transmitter's credit counter, reset to `TOT_FIFO_DEPTH`, stays exact. The block sits at the root quadtree router's LOCAL input, facing the root node's output unit.

## Interface
- `FIFO_DEPTH`, default `` `TOT_FIFO_DEPTH ``: buffer entries; must be a power of 2, ≥2, and equal to the transmitter's credit reset value.
- `WIDTH`, default `` `ROUTER_WIDTH `` (36): flit width.
- `clk`, input, 1: system clock; the only clock.
- `rst`, input, 1: system reset; synchronous, active-high.
- `in_data_valid`, input, 1: flit present on `in_data` this cycle; single-cycle qualifier, no backpressure.
- `in_data`, input, WIDTH: flit; `[35:32]` info, `[31:16]` addr, `[15:0]` data.
- `upstream_credit`, output, 1: one-cycle pulse per consumed flit, returned to the transmitter.
- `out_vld`, output, 1: head flit valid.
- `out_rdy`, input, 1: consumer accepts the head flit.
- `out_flit`, output, WIDTH: head flit, undecoded.
- `out_info`, output, `` `ROUTER_INFO_WIDTH ``: equals `out_flit[35:32]`.
- `out_addr`, output, `` `ROUTER_ADDR_WIDTH ``: equals `out_flit[31:16]`.
- `out_data`, output, `` `ROUTER_DATA_WIDTH ``: equals `out_flit[15:0]`.
- `fifo_count`, output, $clog2(FIFO_DEPTH)+1: current occupancy.
- `read_pkt_cnt`, output, 16: saturating count of consumed flits with `out_info == `ROUTER_INFO_READ``.
- `overflow_err`, output, 1: sticky overflow flag (see Configuration).

## Operation
- Storage is a circular buffer of FIFO_DEPTH × WIDTH.
  - Write pointer, read pointer and occupancy count are registers.
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally from FIFO_DEPTH−1 to 0.
- Push condition: `in_data_valid` and (count < FIFO_DEPTH, or pop in the same cycle).
- Pop condition: `out_vld && out_rdy`.
- Count update rules:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle: unchanged; this holds also at count == FIFO_DEPTH and at count == 1.
- Output path is first-word-fall-through:
  - `out_vld = (count != 0)`.
  - `out_flit = mem[rd_ptr]`.
  - Decoded fields are pure slices of `out_flit`.
- When `out_vld` is 0, `out_flit` is don't-care; the bench must not check it.
- Holding rule: `out_flit` is stable while `out_vld && !out_rdy`.
- Credit: `upstream_credit` is registered. It is 1 in the cycle after each pop and 0 otherwise, so back-to-back pops produce back-to-back pulses.
- `read_pkt_cnt` increments on a pop whose `out_info` is READ. It saturates at 16'hFFFF.
- Overflow event: `in_data_valid` while count == FIFO_DEPTH and no pop.
  - The flit is dropped.
  - Pointers and count are unchanged.
  - Under a correct credit protocol this event never occurs.
- Reset, including reset asserted mid-stream:
  - Next edge: pointers 0, count 0, `out_vld` 0, `upstream_credit` 0, `read_pkt_cnt` 0, `overflow_err` 0.
  - Any flits in flight are discarded.
  - No credits are returned for discarded flits; the transmitter resets concurrently.

## Timing
- Ingress to egress: a flit pushed at edge N into an empty buffer gives `out_vld` = 1 after edge N, so it is consumable in cycle N+1.
- Pop to credit: a pop in cycle N gives `upstream_credit` = 1 during cycle N+1.
- Credit round trip: transmitter decrements at send; this block returns the credit 1 cycle after consumption.
- Throughput: one push and one pop per cycle sustained, with no bubbles.
- `fifo_count`, `read_pkt_cnt` and `overflow_err` update at the edge following the event.

## Configuration
- Macro: `ROOT_INPUT_OVERFLOW_CHECK_EN`.
- Defined:
  - `overflow_err` is set on the edge after the first overflow event.
  - It stays set until `rst`.
  - It drives a `$display` warning in simulation.
- Undefined:
  - `overflow_err` is constant 0 and the overflow detection logic is absent.
  - Overflowing flits are still dropped silently.

## Test plan
- Single flit: reset, then inject `in_data`=36'h2_0123_ABCD with `out_rdy`=1.
  - `out_vld` is 1 one cycle later with `out_info`=2, `out_addr`=16'h0123, `out_data`=16'hABCD.
  - `upstream_credit` pulses exactly once, one cycle after the pop.
- Fill: with `out_rdy`=0, inject FIFO_DEPTH flits carrying values 0..FIFO_DEPTH−1.
  - `fifo_count`=FIFO_DEPTH and no credits are returned.
  - Raising `out_rdy` drains the values in order and returns FIFO_DEPTH consecutive credit pulses.
- Full with simultaneous push/pop: at count = FIFO_DEPTH, push and pop in the same cycle.
  - Count stays FIFO_DEPTH, the new flit is retained, `overflow_err` stays 0, and one credit is returned.
- Overflow: at full with `out_rdy`=0, inject one extra flit.
  - The extra flit is dropped and count is unchanged.
  - `overflow_err`=1 with the macro defined and 0 without it.
- Wrap-around and counting:
  - Stream 3×FIFO_DEPTH flits with random `out_rdy`; output order is preserved.
  - Inject 5 READ flits and 3 non-READ flits; `read_pkt_cnt` reads 5.
- Reset mid-stream: assert `rst` at count = 3.
  - Next cycle: `out_vld`=0, `fifo_count`=0, `read_pkt_cnt`=0, and no `upstream_credit` pulse.

Source files
------------

// File: rtl/root_input_unit.sv
// -----------------------------------------------------------------------------
// root_input_unit
//
// Receiver for the LOCAL port link of the root quadtree router. Incoming flits
// are captured into a first-word-fall-through circular buffer and offered to a
// consumer over a valid/ready handshake. Each consumed flit returns one
// registered credit pulse to the upstream transmitter, whose credit counter is
// reset to the same depth as this buffer.
//
// Optional feature macro: ROOT_INPUT_OVERFLOW_CHECK_EN
//   defined   : overflow_err is a sticky flag set after the first write into a
//               full buffer that is not being drained in the same cycle.
//   undefined : overflow_err is tied to 0; overflowing flits are still dropped.
//
// Ports
//   clk             system clock
//   rst             synchronous active-high reset
//   in_data_valid   flit present on in_data (no backpressure)
//   in_data         incoming flit {info, addr, data}
//   upstream_credit one-cycle pulse per consumed flit
//   out_vld         head flit valid
//   out_rdy         consumer accepts the head flit
//   out_flit        head flit, undecoded
//   out_info        out_flit info field
//   out_addr        out_flit addr field
//   out_data        out_flit data field
//   fifo_count      current buffer occupancy
//   read_pkt_cnt    saturating count of consumed READ flits
//   overflow_err    sticky overflow flag (see macro above)
// -----------------------------------------------------------------------------

`ifndef TOT_FIFO_DEPTH
  `define TOT_FIFO_DEPTH 8
`endif
`ifndef ROUTER_WIDTH
  `define ROUTER_WIDTH 36
`endif
`ifndef ROUTER_INFO_WIDTH
  `define ROUTER_INFO_WIDTH 4
`endif
`ifndef ROUTER_ADDR_WIDTH
  `define ROUTER_ADDR_WIDTH 16
`endif
`ifndef ROUTER_DATA_WIDTH
  `define ROUTER_DATA_WIDTH 16
`endif
`ifndef ROUTER_INFO_READ
  `define ROUTER_INFO_READ 4'd1
`endif

module root_input_unit #(
  parameter int FIFO_DEPTH = `TOT_FIFO_DEPTH,
  parameter int WIDTH      = `ROUTER_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_data_valid,
  input  logic [WIDTH-1:0]                in_data,
  output logic                            upstream_credit,
  output logic                            out_vld,
  input  logic                            out_rdy,
  output logic [WIDTH-1:0]                out_flit,
  output logic [`ROUTER_INFO_WIDTH-1:0]   out_info,
  output logic [`ROUTER_ADDR_WIDTH-1:0]   out_addr,
  output logic [`ROUTER_DATA_WIDTH-1:0]   out_data,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic [15:0]                     read_pkt_cnt,
  output logic                            overflow_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = `ROUTER_INFO_WIDTH;
  localparam int AW = `ROUTER_ADDR_WIDTH;
  localparam int DW = `ROUTER_DATA_WIDTH;

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [IW-1:0] INFO_READ = IW'(`ROUTER_INFO_READ);

  // Storage and pointers
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic full;
  logic pop;
  logic push;

  assign full = (count == DEPTH_C);
  assign pop  = out_vld && out_rdy;
  // A full buffer still accepts a flit when the head leaves in the same cycle.
  assign push = in_data_valid && (!full || pop);

  // First-word-fall-through output path
  assign out_vld    = (count != '0);
  assign out_flit   = mem[rd_ptr];
  assign out_info   = out_flit[DW+AW +: IW];
  assign out_addr   = out_flit[DW    +: AW];
  assign out_data   = out_flit[0     +: DW];
  assign fifo_count = count;

  // Buffer write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Credit return: one registered pulse per consumed flit
  always_ff @(posedge clk) begin
    if (rst) begin
      upstream_credit <= 1'b0;
    end else begin
      upstream_credit <= pop;
    end
  end

  // Saturating READ flit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      read_pkt_cnt <= '0;
    end else if (pop && (out_info == INFO_READ) && (read_pkt_cnt != '1)) begin
      read_pkt_cnt <= read_pkt_cnt + 16'd1;
    end
  end

`ifdef ROOT_INPUT_OVERFLOW_CHECK_EN
  logic overflow_ev;
  logic overflow_q;

  assign overflow_ev  = in_data_valid && full && !pop;
  assign overflow_err = overflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (overflow_ev) begin
      overflow_q <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && overflow_ev) begin
      $display("WARNING root_input_unit: flit dropped on full buffer at %0t", $time);
    end
  end
`endif
`else
  assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_root_input_unit.sv
// -----------------------------------------------------------------------------
// tb_root_input_unit
//
// Directed bench for root_input_unit. A queue-based reference model tracks the
// buffer contents, credits, READ count and overflow flag; a compare process
// checks every DUT output against it on each negative clock edge. Directed
// steps add literal expectations that pin the model.
// -----------------------------------------------------------------------------

`ifndef TOT_FIFO_DEPTH
  `define TOT_FIFO_DEPTH 8
`endif
`ifndef ROUTER_INFO_READ
  `define ROUTER_INFO_READ 4'd1
`endif

module tb_root_input_unit;

  localparam int D  = `TOT_FIFO_DEPTH;
  localparam int W  = 36;
  localparam int CW = $clog2(D) + 1;
  localparam logic [3:0] RD = 4'(`ROUTER_INFO_READ);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_data_valid;
  logic [W-1:0]  in_data;
  logic          upstream_credit;
  logic          out_vld;
  logic          out_rdy;
  logic [W-1:0]  out_flit;
  logic [3:0]    out_info;
  logic [15:0]   out_addr;
  logic [15:0]   out_data;
  logic [CW-1:0] fifo_count;
  logic [15:0]   read_pkt_cnt;
  logic          overflow_err;

  root_input_unit #(.FIFO_DEPTH(D), .WIDTH(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_data_valid   (in_data_valid),
    .in_data         (in_data),
    .upstream_credit (upstream_credit),
    .out_vld         (out_vld),
    .out_rdy         (out_rdy),
    .out_flit        (out_flit),
    .out_info        (out_info),
    .out_addr        (out_addr),
    .out_data        (out_data),
    .fifo_count      (fifo_count),
    .read_pkt_cnt    (read_pkt_cnt),
    .overflow_err    (overflow_err)
  );

  always #5 clk = ~clk;

`ifdef ROOT_INPUT_OVERFLOW_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  logic [W-1:0] q[$];
  bit           m_credit = 1'b0;
  int           m_rpc    = 0;
  bit           m_ovf    = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_credit = 1'b0;
      m_rpc    = 0;
      m_ovf    = 1'b0;
    end else begin
      bit was_full;
      bit popped;
      logic [W-1:0] head;
      was_full = (q.size() == D);
      popped   = (q.size() > 0) && out_rdy;
      m_credit = popped;
      if (popped) begin
        head = q.pop_front();
        if (head[35:32] == RD && m_rpc < 65535) m_rpc++;
      end
      if (in_data_valid) begin
        if (!was_full || popped) q.push_back(in_data);
        else if (OVF_EN) m_ovf = 1'b1;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (checking) begin
      chk("out_vld", 64'(out_vld), 64'(q.size() > 0));
      if (q.size() > 0) begin
        chk("out_flit", 64'(out_flit), 64'(q[0]));
        chk("out_fields", 64'({out_info, out_addr, out_data}), 64'(q[0]));
      end
      chk("fifo_count", 64'(fifo_count), 64'(q.size()));
      chk("upstream_credit", 64'(upstream_credit), 64'(m_credit));
      chk("read_pkt_cnt", 64'(read_pkt_cnt), 64'(m_rpc));
      chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int base);
    out_rdy = 1'b0;
    for (int i = 0; i < D; i++) begin
      in_data_valid = 1'b1;
      in_data = 36'(base + i);
      tick();
    end
    in_data_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    out_rdy = 1'b1;
    in_data_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
    out_rdy = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_data_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int pushed;
    int guard;
    rst = 1'b1;
    in_data_valid = 1'b0;
    in_data = '0;
    out_rdy = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checking = 1'b1;

    // Reset state
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_credit", 64'(upstream_credit), 64'd0);

    // Single flit
    out_rdy = 1'b1;
    in_data_valid = 1'b1;
    in_data = 36'h2_0123_ABCD;
    tick();
    in_data_valid = 1'b0;
    chk("single_vld", 64'(out_vld), 64'd1);
    chk("single_info", 64'(out_info), 64'h2);
    chk("single_addr", 64'(out_addr), 64'h0123);
    chk("single_data", 64'(out_data), 64'hABCD);
    chk("single_nocredit_yet", 64'(upstream_credit), 64'd0);
    tick();
    chk("single_credit", 64'(upstream_credit), 64'd1);
    chk("single_empty", 64'(out_vld), 64'd0);
    tick();
    chk("single_credit_once", 64'(upstream_credit), 64'd0);
    out_rdy = 1'b0;

    // Fill then ordered drain with back-to-back credits
    fill(0);
    chk("fill_count", 64'(fifo_count), 64'(D));
    chk("fill_nocredit", 64'(upstream_credit), 64'd0);
    out_rdy = 1'b1;
    for (int i = 0; i < D; i++) begin
      chk("drain_vld", 64'(out_vld), 64'd1);
      chk("drain_val", 64'(out_data), 64'(i));
      tick();
      chk("drain_credit", 64'(upstream_credit), 64'd1);
    end
    out_rdy = 1'b0;
    tick();
    chk("drain_credit_end", 64'(upstream_credit), 64'd0);
    chk("drain_empty", 64'(fifo_count), 64'd0);

    // Full with simultaneous push and pop
    fill(16'h100);
    in_data_valid = 1'b1;
    in_data = 36'hF_FFFF_0077;
    out_rdy = 1'b1;
    tick();
    in_data_valid = 1'b0;
    out_rdy = 1'b0;
    chk("fullpp_count", 64'(fifo_count), 64'(D));
    chk("fullpp_credit", 64'(upstream_credit), 64'd1);
    chk("fullpp_ovf", 64'(overflow_err), 64'd0);
    chk("fullpp_head", 64'(out_data), 64'h101);
    drain(D + 2);

    // Overflow at full
    fill(16'h200);
    in_data_valid = 1'b1;
    in_data = 36'h0_0000_DEAD;
    tick();
    in_data_valid = 1'b0;
    chk("ovf_count", 64'(fifo_count), 64'(D));
    chk("ovf_flag", 64'(overflow_err), 64'(OVF_EN));
    drain(D + 2);
    chk("ovf_sticky", 64'(overflow_err), 64'(OVF_EN));

    // Wrap-around stream with random ready
    do_reset();
    tick();
    chk("post_rst_ovf", 64'(overflow_err), 64'd0);
    pushed = 0;
    guard = 0;
    while (pushed < 3 * D && guard < 2000) begin
      out_rdy = 1'($urandom_range(0, 1));
      if (q.size() < D) begin
        in_data_valid = 1'b1;
        in_data = 36'(16'h300 + pushed);
        pushed++;
      end else begin
        in_data_valid = 1'b0;
      end
      tick();
      guard++;
    end
    chk("wrap_progress", 64'(pushed), 64'(3 * D));
    drain(D + 2);

    // READ counting: 5 READ and 3 other flits, interleaved
    do_reset();
    out_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [3:0] info;
      info = (i % 3 == 1) ? 4'h2 : RD;
      in_data_valid = 1'b1;
      in_data = {info, 16'(i), 16'(i)};
      tick();
    end
    in_data_valid = 1'b0;
    tick();
    tick();
    chk("read_cnt", 64'(read_pkt_cnt), 64'd5);

    // Reset mid-stream at count 3
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data_valid = 1'b1;
      in_data = 36'(16'h400 + i);
      tick();
    end
    in_data_valid = 1'b0;
    chk("mid_count3", 64'(fifo_count), 64'd3);
    out_rdy = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_vld", 64'(out_vld), 64'd0);
    chk("mid_count", 64'(fifo_count), 64'd0);
    chk("mid_rpc", 64'(read_pkt_cnt), 64'd0);
    chk("mid_credit", 64'(upstream_credit), 64'd0);
    tick();
    chk("mid_credit_after", 64'(upstream_credit), 64'd0);
    tick();

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
